// File: rtl/snn_aer_pkg.sv
// snn_aer_pkg: shared types and constants for the AER output stage
package snn_aer_pkg;
    typedef enum logic [1:0] {IDLE, REQ_HI, ACK_LO} aer_out_state_t;
    localparam int AER_SYNC_STAGES = 2;
endpackage

// File: rtl/aer_spike_out_if.sv
// aer_spike_out_if: 4-phase AER REQ/ACK bus toward the SNN core
interface aer_spike_out_if #(
    parameter int ADDR_BITS = 10
);
    logic [ADDR_BITS-1:0] AEROUT_ADDR;
    logic                 AEROUT_REQ;
    logic                 AEROUT_ACK;
    modport master (output AEROUT_ADDR, output AEROUT_REQ, input AEROUT_ACK);
    modport slave (input AEROUT_ADDR, input AEROUT_REQ, output AEROUT_ACK);
endinterface

// File: rtl/aer_index_fifo.sv
// aer_index_fifo: power-of-two circular buffer of pixel indices with occupancy count
module aer_index_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           din_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;
    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/aer_spike_out.sv
// aer_spike_out: buffers sorted pixel indices and emits them as 4-phase AER events
module aer_spike_out
    import snn_aer_pkg::*;
#(
    parameter int IMAGE_SIZE = 784,
    parameter int ADDR_BITS  = $clog2(IMAGE_SIZE),
    parameter int CNT_BITS   = $clog2(IMAGE_SIZE + 1),
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [ADDR_BITS-1:0] NEXT_INDEX,
    input  logic                 FOUND_NEXT_INDEX,
    input  logic                 NEW_IMAGE,
    output logic                 AEROUT_CTRL_BUSY,
    output logic [CNT_BITS-1:0]  EVENTS_SENT,
    output logic                 IMAGE_DONE,
    output logic                 OVERFLOW,
    aer_spike_out_if.master      aer
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    aer_out_state_t             state_q;
    logic [AER_SYNC_STAGES-1:0] ack_q;
    logic [ADDR_BITS-1:0]       addr_q, head;
    logic [CNT_BITS-1:0]        events_q, events_d;
    logic [CW-1:0]              count;
    logic                       req_q, done_q, done_d, ovf_q, ovf_d;
    logic                       full, empty, pop, ack_s, complete, wrap;
    aer_index_fifo #(.WIDTH(ADDR_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .push_i  (FOUND_NEXT_INDEX),
        .pop_i   (pop),
        .din_i   (NEXT_INDEX),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );
    // one slot of headroom covers the sorter's strobe issued on a stale BUSY sample
    assign AEROUT_CTRL_BUSY = count >= CW'(FIFO_DEPTH - 1);
    assign pop              = state_q == IDLE && !empty;
    assign ack_s            = ack_q[AER_SYNC_STAGES-1];
    assign aer.AEROUT_REQ   = req_q;
    assign aer.AEROUT_ADDR  = addr_q;
    assign EVENTS_SENT      = events_q;
    assign IMAGE_DONE       = done_q;
    assign OVERFLOW         = ovf_q;
    always_comb begin
        complete = state_q == ACK_LO && !ack_s;
        wrap     = events_q == CNT_BITS'(IMAGE_SIZE - 1);
        events_d = NEW_IMAGE ? '0 : complete ? (wrap ? '0 : events_q + 1'b1) : events_q;
        done_d   = complete && wrap && !NEW_IMAGE;
        ovf_d    = NEW_IMAGE ? 1'b0 : (ovf_q || (FOUND_NEXT_INDEX && full));
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            ack_q    <= '0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            events_q <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            ack_q    <= {ack_q[AER_SYNC_STAGES-2:0], aer.AEROUT_ACK};
            events_q <= events_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            case (state_q)
                IDLE: if (!empty) begin
                    addr_q  <= head;
                    req_q   <= 1'b1;
                    state_q <= REQ_HI;
                end
                REQ_HI: if (ack_s) begin
                    req_q   <= 1'b0;
                    state_q <= ACK_LO;
                end
                ACK_LO: if (!ack_s) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aer_spike_out.sv
// tb_aer_spike_out: directed bench for aer_spike_out with IMAGE_SIZE=5, 10-bit addresses
module tb_aer_spike_out;
    logic       CLK, RST, FOUND, NEW_IMAGE, BUSY, IMAGE_DONE, OVERFLOW;
    logic [9:0] NEXT_INDEX;
    logic [2:0] EVENTS_SENT;
    int         checks = 0, errors = 0, done_cnt = 0;

    aer_spike_out_if #(.ADDR_BITS(10)) aer_bus ();

    aer_spike_out #(.IMAGE_SIZE(5), .ADDR_BITS(10), .CNT_BITS(3), .FIFO_DEPTH(4)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .NEXT_INDEX       (NEXT_INDEX),
        .FOUND_NEXT_INDEX (FOUND),
        .NEW_IMAGE        (NEW_IMAGE),
        .AEROUT_CTRL_BUSY (BUSY),
        .EVENTS_SENT      (EVENTS_SENT),
        .IMAGE_DONE       (IMAGE_DONE),
        .OVERFLOW         (OVERFLOW),
        .aer              (aer_bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        #1;
        if (IMAGE_DONE) done_cnt++;
    end

    typedef struct {
        logic [9:0] idx;
        logic [9:0] exp_addr;
        logic [2:0] exp_cnt;
        logic       exp_done;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push1(input logic [9:0] idx);
        NEXT_INDEX = idx;
        FOUND      = 1'b1;
        @(negedge CLK);
        FOUND      = 1'b0;
    endtask

    task automatic pulse_new_image();
        NEW_IMAGE = 1'b1;
        @(negedge CLK);
        NEW_IMAGE = 1'b0;
    endtask

    // one full handshake; returns at the negedge right after the completion edge
    task automatic hs(input int dly, input logic ni, output logic [9:0] a);
        int n = 0;
        a = '0;
        while (!aer_bus.AEROUT_REQ && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (!aer_bus.AEROUT_REQ) begin
            chk("hs_req_timeout", 0, 1);
            return;
        end
        a = aer_bus.AEROUT_ADDR;
        repeat (dly) @(negedge CLK);
        aer_bus.AEROUT_ACK = 1'b1;
        n = 0;
        while (aer_bus.AEROUT_REQ && n < 50) begin
            @(negedge CLK);
            n++;
        end
        aer_bus.AEROUT_ACK = 1'b0;
        if (aer_bus.AEROUT_REQ) begin
            chk("hs_fall_timeout", 1, 0);
            return;
        end
        @(negedge CLK);
        @(negedge CLK);
        if (ni) NEW_IMAGE = 1'b1;
        @(negedge CLK);
        NEW_IMAGE = 1'b0;
    endtask

    initial begin
        vec_t       tbl [5];
        logic [9:0] a;
        logic       pend, seen;
        int         strobes, at_busy, d0;
        tbl[0] = '{10'd4, 10'd4, 3'd1, 1'b0};
        tbl[1] = '{10'd0, 10'd0, 3'd2, 1'b0};
        tbl[2] = '{10'd3, 10'd3, 3'd3, 1'b0};
        tbl[3] = '{10'd1, 10'd1, 3'd4, 1'b0};
        tbl[4] = '{10'd2, 10'd2, 3'd0, 1'b1};
        RST = 1'b1; FOUND = 1'b0; NEW_IMAGE = 1'b0; NEXT_INDEX = '0;
        aer_bus.AEROUT_ACK = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        chk("rst_req", aer_bus.AEROUT_REQ, 0);
        chk("rst_addr", aer_bus.AEROUT_ADDR, 0);
        chk("rst_events", EVENTS_SENT, 0);
        chk("rst_done", IMAGE_DONE, 0);
        chk("rst_ovf", OVERFLOW, 0);
        chk("rst_busy", BUSY, 0);

        // single event with exact edge timing, responder delay 3 cycles
        push1(10'd37);
        chk("t1_req_not_yet", aer_bus.AEROUT_REQ, 0);
        @(negedge CLK);
        chk("t1_req_rise", aer_bus.AEROUT_REQ, 1);
        chk("t1_addr", aer_bus.AEROUT_ADDR, 37);
        repeat (2) @(negedge CLK);
        aer_bus.AEROUT_ACK = 1'b1;
        @(negedge CLK);
        chk("t1_req_hold_a", aer_bus.AEROUT_REQ, 1);
        @(negedge CLK);
        chk("t1_req_hold_a1", aer_bus.AEROUT_REQ, 1);
        @(negedge CLK);
        chk("t1_req_fall_a2", aer_bus.AEROUT_REQ, 0);
        aer_bus.AEROUT_ACK = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("t1_events_pending", EVENTS_SENT, 0);
        @(negedge CLK);
        chk("t1_events", EVENTS_SENT, 1);
        chk("t1_addr_hold", aer_bus.AEROUT_ADDR, 37);

        // full image of back-to-back strobes, drained in push order
        pulse_new_image();
        chk("t2_new_image_clr", EVENTS_SENT, 0);
        for (int i = 0; i < 5; i++) begin
            NEXT_INDEX = tbl[i].idx;
            FOUND      = 1'b1;
            @(negedge CLK);
        end
        FOUND = 1'b0;
        chk("t2_ovf", OVERFLOW, 0);
        for (int i = 0; i < 5; i++) begin
            hs(1, 1'b0, a);
            chk($sformatf("t2_addr_%0d", i), a, tbl[i].exp_addr);
            chk($sformatf("t2_cnt_%0d", i), EVENTS_SENT, tbl[i].exp_cnt);
            chk($sformatf("t2_done_%0d", i), IMAGE_DONE, tbl[i].exp_done);
        end
        @(negedge CLK);
        chk("t2_done_one_cycle", IMAGE_DONE, 0);
        chk("t2_done_count", done_cnt, 1);

        // well-behaved sorter against a stalled core
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        pend = 1'b0; strobes = 0; at_busy = -1;
        for (int c = 0; c < 15; c++) begin
            if (BUSY && at_busy < 0) at_busy = strobes;
            FOUND      = pend;
            NEXT_INDEX = 10'(100 + strobes);
            if (pend) strobes++;
            pend = !BUSY;
            @(negedge CLK);
        end
        FOUND = 1'b0;
        chk("t3_busy_at_occ3", at_busy, 4);
        chk("t3_accepted", strobes, 5);
        chk("t3_busy_end", BUSY, 1);
        chk("t3_ovf", OVERFLOW, 0);

        // raw strobes into a full FIFO
        NEXT_INDEX = 10'd900;
        FOUND      = 1'b1;
        repeat (2) @(negedge CLK);
        FOUND = 1'b0;
        chk("t4_ovf_set", OVERFLOW, 1);
        @(negedge CLK);
        chk("t4_ovf_sticky", OVERFLOW, 1);
        pulse_new_image();
        chk("t4_ovf_clr", OVERFLOW, 0);
        for (int i = 0; i < 5; i++) begin
            hs(2, 1'b0, a);
            chk($sformatf("t4_drain_%0d", i), a, 100 + i);
        end
        seen = 1'b0;
        repeat (20) begin
            @(negedge CLK);
            if (aer_bus.AEROUT_REQ) seen = 1'b1;
        end
        chk("t4_no_dropped_event", seen, 0);

        // reset in the middle of a handshake with two entries buffered
        push1(10'd7);
        hs(1, 1'b0, a);
        chk("t5_pre_events", EVENTS_SENT, 1);
        NEXT_INDEX = 10'd11; FOUND = 1'b1;
        @(negedge CLK);
        NEXT_INDEX = 10'd12;
        @(negedge CLK);
        NEXT_INDEX = 10'd13;
        @(negedge CLK);
        FOUND = 1'b0;
        chk("t5_in_req_hi", aer_bus.AEROUT_REQ, 1);
        chk("t5_in_addr", aer_bus.AEROUT_ADDR, 11);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("t5_req", aer_bus.AEROUT_REQ, 0);
        chk("t5_busy", BUSY, 0);
        chk("t5_events", EVENTS_SENT, 0);
        chk("t5_addr", aer_bus.AEROUT_ADDR, 0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge CLK);
            if (aer_bus.AEROUT_REQ) seen = 1'b1;
        end
        chk("t5_no_stale", seen, 0);

        // NEW_IMAGE coinciding with the closing completion of an image
        d0 = done_cnt;
        for (int i = 0; i < 5; i++) begin
            push1(10'(200 + i));
            hs(1, i == 4, a);
            chk($sformatf("t6_addr_%0d", i), a, 200 + i);
            if (i == 3) chk("t6_cnt_before", EVENTS_SENT, 4);
        end
        chk("t6_events", EVENTS_SENT, 0);
        chk("t6_done", IMAGE_DONE, 0);
        @(negedge CLK);
        chk("t6_done_count", done_cnt, d0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
